// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage.
//               fetch_entry_t  - {pc, instr} pair buffered toward decode
//               fetch_state_e  - fetch FSM states (RUN / FAULT)
//               NOP_INSTR      - value shown on the instruction output at reset
//               PC_STEP        - byte increment between sequential fetches
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
  localparam int unsigned PC_STEP   = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Circular buffer of fetched entries with count and flush.
//               Pointers wrap at DEPTH, which need not be a power of two.
// Ports       : clk, rst_n            - clock, async active-low reset
//               enq_i / enq_data_i    - enqueue strobe and entry
//               deq_i                 - pop the head entry
//               flush_i               - discard all entries (wins over enq/deq)
//               head_o                - entry at the read pointer
//               count_o               - number of valid entries
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int unsigned DEPTH     = 2,
  parameter type         T         = logic,
  parameter T            RESET_VAL = '0,
  localparam int unsigned CW       = $clog2(DEPTH + 1),
  localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enq_i,
  input  T              enq_data_i,
  input  logic          deq_i,
  input  logic          flush_i,
  output T              head_o,
  output logic [CW-1:0] count_o
);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_i) begin
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (deq_i) begin
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({enq_i, deq_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (enq_i && !flush_i) begin
        mem_q[wr_ptr_q] <= enq_data_i;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the PC, reads a combinational
//               instruction memory, buffers {pc, instr} toward decode and
//               handles redirects (flush + restart, or halt on misalignment).
// Ports       : clk, rst_n            - clock, async active-low reset
//               imem_addr_o           - word address (pc_q[WIDTH-1:2])
//               imem_data_i           - instruction word, same cycle
//               redirect_valid_i/pc_i - restart request and byte target
//               out_valid_o/ready_i   - decode handshake
//               out_instr_o/out_pc_o  - head entry
//               fetch_fault_o         - misaligned redirect, fetch halted
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned      FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-3:0] imem_addr_o,
  input  logic [WIDTH-1:0] imem_data_i,
  input  logic             redirect_valid_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_instr_o,
  output logic [WIDTH-1:0] out_pc_o,
  output logic             fetch_fault_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } entry_t;

  localparam entry_t        C_RESET_ENTRY = '{pc: '0, instr: WIDTH'(NOP_INSTR)};
  localparam logic [CW-1:0] C_DEPTH       = CW'(FIFO_DEPTH);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             fetch_fire;
  logic             deq;
  logic [CW-1:0]    count_q;
  entry_t           head;
  entry_t           enq_data;

  // Redirect outranks everything: it overrides the PC, flushes the buffer
  // and suppresses the enqueue of the word fetched this cycle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_fire = 1'b0;
    if (redirect_valid_i) begin
      pc_d    = {redirect_pc_i[WIDTH-1:2], 2'b00};
      state_d = (redirect_pc_i[1:0] == 2'b00) ? RUN : FAULT;
    end else if (state_q == RUN && count_q < C_DEPTH) begin
      // Registered count only: a same-cycle pop never opens a full buffer.
      fetch_fire = 1'b1;
      pc_d       = pc_q + WIDTH'(PC_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign enq_data = '{pc: pc_q, instr: imem_data_i};
  // A handshake coinciding with a redirect is absorbed by the flush.
  assign deq      = out_valid_o && out_ready_i && !redirect_valid_i;

  fetch_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .T         (entry_t),
    .RESET_VAL (C_RESET_ENTRY)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .enq_i      (fetch_fire),
    .enq_data_i (enq_data),
    .deq_i      (deq),
    .flush_i    (redirect_valid_i),
    .head_o     (head),
    .count_o    (count_q)
  );

  assign imem_addr_o   = pc_q[WIDTH-1:2];
  assign out_valid_o   = (count_q != '0) && (state_q == RUN);
  assign out_instr_o   = head.instr;
  assign out_pc_o      = head.pc;
  assign fetch_fault_o = (state_q == FAULT);

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed, scoreboard-based bench for fetch_unit. Expected
//               {pc, instr} pairs are queued as stimulus is applied and popped
//               on every decode handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [29:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_o;
  logic        fetch_fault_o;

  int checks = 0;
  int errors = 0;
  fetch_entry_t exp_q[$];

  fetch_unit #(
    .WIDTH      (32),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_addr_o      (imem_addr_o),
    .imem_data_i      (imem_data_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_instr_o      (out_instr_o),
    .out_pc_o         (out_pc_o),
    .fetch_fault_o    (fetch_fault_o)
  );

  // Instruction memory: mem[i] = 0x1000 + i
  assign imem_data_i = 32'h1000 + {2'b00, imem_addr_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    logic [31:0] pc;
    fetch_entry_t e;
    for (int i = 0; i < n; i++) begin
      pc = start + 32'(4 * i);
      e.pc = pc;
      e.instr = 32'h1000 + (pc >> 2);
      exp_q.push_back(e);
    end
  endtask

  // Score the handshake (if any) for the upcoming edge, then advance past it.
  task automatic tick();
    fetch_entry_t e;
    if (out_valid_o && out_ready_i) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_underflow: observed pc %0h expected no entry", out_pc_o);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_pc", {32'h0, out_pc_o}, {32'h0, e.pc});
        check("sb_instr", {32'h0, out_instr_o}, {32'h0, e.instr});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] target, input int n_push);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = target;
    tick();
    redirect_valid_i = 1'b0;
    exp_q.delete();
    if (n_push > 0) push_stream(target, n_push);
  endtask

  initial begin
    rst_n            = 1'b0;
    out_ready_i      = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_valid", {63'h0, out_valid_o}, 64'h0);
    check("rst_fault", {63'h0, fetch_fault_o}, 64'h0);
    check("rst_instr", {32'h0, out_instr_o}, 64'h13);
    check("rst_pc", {32'h0, out_pc_o}, 64'h0);
    check("rst_addr", {34'h0, imem_addr_o}, 64'h0);

    // Release: first entry valid one edge later, then one per cycle
    push_stream(32'h0, 64);
    rst_n = 1'b1;
    tick();
    check("first_valid", {63'h0, out_valid_o}, 64'h1);
    check("first_pc", {32'h0, out_pc_o}, 64'h0);
    for (int i = 0; i < 6; i++) begin
      check("no_bubble", {63'h0, out_valid_o}, 64'h1);
      tick();
    end

    // Backpressure: head (pc 24) holds, fetch stalls at two entries
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("bp_valid", {63'h0, out_valid_o}, 64'h1);
    check("bp_head_pc", {32'h0, out_pc_o}, 64'd24);
    check("bp_addr", {34'h0, imem_addr_o}, 64'd8);
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Redirect to 0x40 with a full buffer
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    redirect(32'h40, 16);
    check("rd_bubble", {63'h0, out_valid_o}, 64'h0);
    check("rd_addr", {34'h0, imem_addr_o}, 64'h10);
    out_ready_i = 1'b1;
    tick();
    check("rd_valid", {63'h0, out_valid_o}, 64'h1);
    check("rd_pc", {32'h0, out_pc_o}, 64'h40);
    for (int i = 0; i < 3; i++) tick();

    // Misaligned redirect -> FAULT, held for 10 cycles
    redirect(32'h42, 0);
    check("flt_set", {63'h0, fetch_fault_o}, 64'h1);
    check("flt_addr", {34'h0, imem_addr_o}, 64'h10);
    for (int i = 0; i < 10; i++) begin
      check("flt_novalid", {63'h0, out_valid_o}, 64'h0);
      check("flt_hold", {63'h0, fetch_fault_o}, 64'h1);
      tick();
    end

    // Aligned redirect out of FAULT
    redirect(32'h80, 16);
    check("flt_clear", {63'h0, fetch_fault_o}, 64'h0);
    check("flt_bubble", {63'h0, out_valid_o}, 64'h0);
    tick();
    check("flt_rec_valid", {63'h0, out_valid_o}, 64'h1);
    check("flt_rec_pc", {32'h0, out_pc_o}, 64'h80);
    for (int i = 0; i < 2; i++) tick();

    // PC wrap around 2^32
    redirect(32'hFFFF_FFF8, 16);
    tick();
    for (int i = 0; i < 4; i++) tick();

    // Asynchronous reset with two entries buffered
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("mr_pre_valid", {63'h0, out_valid_o}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_valid", {63'h0, out_valid_o}, 64'h0);
    check("mr_addr", {34'h0, imem_addr_o}, 64'h0);
    check("mr_pc", {32'h0, out_pc_o}, 64'h0);
    check("mr_instr", {32'h0, out_instr_o}, 64'h13);
    @(posedge clk);
    #1;
    exp_q.delete();
    push_stream(32'h0, 16);
    out_ready_i = 1'b1;
    rst_n = 1'b1;
    tick();
    check("mr_restart_pc", {32'h0, out_pc_o}, 64'h0);
    for (int i = 0; i < 4; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the word-aligned address into the instruction memory, which returns data combinationally in the same cycle. Each fetched {pc, instruction} pair is captured into a small buffer and presented to decode through a valid/ready handshake. Control-flow redirects from execute flush the buffer and restart fetch.

Parameters:
WIDTH, 32, datapath and PC width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned
FIFO_DEPTH, 2, number of {pc, instr} entries buffered toward decode; minimum 2

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
imem_addr_o  output  WIDTH-2  word address to instruction memory, equal to pc_q[WIDTH-1:2]
imem_data_i  input  WIDTH  instruction word from instruction memory, valid in the same cycle as imem_addr_o
redirect_valid_i  input  1  one-cycle request to restart fetch at redirect_pc_i
redirect_pc_i  input  WIDTH  byte target PC of the redirect
out_valid_o  output  1  buffer head holds a valid entry
out_ready_i  input  1  decode accepts the head entry this cycle
out_instr_o  output  WIDTH  instruction word of the head entry
out_pc_o  output  WIDTH  byte PC of the head entry
fetch_fault_o  output  1  misaligned redirect target; fetch is halted

Behaviour:
- Reset (async assert, sync release): pc_q=RESET_PC; buffer empty; state=RUN; out_valid_o=0; fetch_fault_o=0; out_instr_o=NOP (32'h00000013); out_pc_o=0; imem_addr_o=RESET_PC>>2.
- States: RUN (fetching) and FAULT (halted).
- In RUN, fetch fires when count_q < FIFO_DEPTH. Fullness uses the registered count only, so a dequeue in the same cycle does not enable a fetch into a full buffer. When fetch fires: enqueue {pc_q, imem_data_i}, then pc_q <= pc_q+4, computed modulo 2^WIDTH (0xFFFFFFFC wraps to 0).
- Latency: the instruction at pc_q is visible on out_* one cycle after the fetch cycle. The first out_valid_o=1 occurs in the first clock edge after rst_n deasserts, with out_pc_o=RESET_PC.
- Dequeue happens when out_valid_o && out_ready_i. out_* shows the head entry and stays stable while out_valid_o=1 && !out_ready_i.
- With no backpressure, steady state is one instruction per cycle.
- Redirect (redirect_valid_i=1) has the highest priority. In that cycle:
  - The buffer is flushed (count <= 0) and no enqueue occurs.
  - Any handshake in the same cycle counts as accepted by decode.
  - If redirect_pc_i[1:0]==0: pc_q <= redirect_pc_i and state <= RUN. out_valid_o is 0 in the next cycle, and the target entry becomes valid the cycle after.
  - Otherwise: pc_q <= redirect_pc_i & ~3, state <= FAULT, and fetch_fault_o is 1 from the next cycle.
- In FAULT: no fetch, out_valid_o=0, fetch_fault_o held at 1. Only an aligned redirect returns to RUN, and fetch_fault_o clears on the same edge. A misaligned redirect keeps the block in FAULT.
- Reset asserted mid-operation immediately restores all reset values, and the buffer contents are discarded.
- Buffer: circular with rd/wr pointers and a count. Pointers wrap at FIFO_DEPTH, which need not be a power of 2.

Decomposition:
- fetch_pkg holds:
  - fetch_entry_t struct {pc, instr}
  - fetch_state_e {RUN, FAULT}
  - NOP_INSTR = 32'h00000013
  - PC_STEP = 4
- One sub-module, fetch_fifo: parameterised by FIFO_DEPTH and entry type, with an enqueue port, a dequeue port, a flush input and a count output.
- fetch_unit holds the PC, the FSM and the redirect priority logic.

Test Plan:
- Release reset with imem returning mem[i]=0x1000+i and out_ready_i=1 → out_pc_o is 0,4,8,12 on consecutive cycles with out_instr_o 0x1000..0x1003, and no bubbles.
- Hold out_ready_i=0 for 5 cycles → out_valid_o=1, head stays at pc 0, imem_addr_o stops at 2 with 2 entries buffered. Release ready → pc 0,4,8 delivered with no loss or duplication.
- Redirect to 0x40 while the buffer is full → next cycle out_valid_o=0, imem_addr_o=0x10; following cycle out_pc_o=0x40 and the old entries are never seen.
- Redirect to 0x42 → fetch_fault_o=1 next cycle and out_valid_o=0 for 10 cycles. Aligned redirect to 0x80 → fault clears and out_pc_o=0x80 two cycles later.
- Redirect to 0xFFFFFFF8 → out_pc_o sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- Assert rst_n=0 mid-stream with the buffer holding 2 entries → out_valid_o=0 and imem_addr_o=RESET_PC>>2 immediately (asynchronously). After release, the stream restarts at RESET_PC.
